// File: rtl/nvcm_seq_pkg.sv
// Shared types and default geometry/timing for the NVCM read sequencer.
// The defaults describe the 1F array and its read timing.
package nvcm_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EN     = 3'd1,
        PUMP   = 3'd2,
        ADDR   = 3'd3,
        READ   = 3'd4,
        SAMPLE = 3'd5,
        OUT    = 3'd6,
        DISCH  = 3'd7
    } seq_state_t;

    localparam int DEF_ROW_W  = 9;
    localparam int DEF_COL_W  = 12;
    localparam int DEF_DATA_W = 9;
    localparam int DEF_LEN_W  = 16;

    localparam int unsigned DEF_MAX_ROW = 32'd303;
    localparam int unsigned DEF_MAX_COL = 32'd1023;

    localparam int DEF_T_EN   = 8;
    localparam int DEF_T_PUMP = 32;
    localparam int DEF_T_RD   = 4;

    // The discharge phase has a fixed length, independent of the array timing.
    localparam int DISCH_CYCLES = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/nvcm_read_sequencer_if.sv
// Request channel (load control -> sequencer) and word stream (sequencer -> bitstream consumer).
interface nvcm_read_sequencer_if
    import nvcm_seq_pkg::*;
#(
    parameter int ROW_W  = DEF_ROW_W,
    parameter int COL_W  = DEF_COL_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
);
    logic              req_valid;
    logic              req_ready;
    logic [ROW_W-1:0]  req_row;
    logic [COL_W-1:0]  req_col;
    logic [LEN_W-1:0]  req_len;
    logic [DATA_W-1:0] dout_data;
    logic              dout_valid;
    logic              dout_ready;

    modport master (
        output req_valid, req_row, req_col, req_len, dout_ready,
        input  req_ready, dout_data, dout_valid
    );

    modport slave (
        input  req_valid, req_row, req_col, req_len, dout_ready,
        output req_ready, dout_data, dout_valid
    );
endinterface

// File: rtl/nvcm_addr_gen.sv
// Loadable row/column counter. The column wraps into the next row; at_end flags
// that the next advance would run past the last row, and such an advance is refused.
module nvcm_addr_gen
    import nvcm_seq_pkg::*;
#(
    parameter int          ROW_W   = DEF_ROW_W,
    parameter int          COL_W   = DEF_COL_W,
    parameter int unsigned MAX_ROW = DEF_MAX_ROW,
    parameter int unsigned MAX_COL = DEF_MAX_COL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [ROW_W-1:0] load_row,
    input  logic [COL_W-1:0] load_col,
    input  logic             adv,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             at_end
);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MAX_ROW);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(MAX_COL);

    logic [ROW_W-1:0] row_r;
    logic [ROW_W-1:0] row_next_s;
    logic [COL_W-1:0] col_r;
    logic [COL_W-1:0] col_next_s;

    assign at_end = (row_r == LAST_ROW) && (col_r == LAST_COL);
    assign row    = row_r;
    assign col    = col_r;

    // Next address: load wins over advance.
    always_comb begin
        row_next_s = row_r;
        col_next_s = col_r;
        if (load) begin
            row_next_s = load_row;
            col_next_s = load_col;
        end else if (adv && !at_end) begin
            if (col_r == LAST_COL) begin
                col_next_s = {COL_W{1'b0}};
                row_next_s = row_r + ROW_W'(1);
            end else begin
                col_next_s = col_r + COL_W'(1);
            end
        end else begin
            row_next_s = row_r;
            col_next_s = col_r;
        end
    end

    // Address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_r <= {ROW_W{1'b0}};
            col_r <= {COL_W{1'b0}};
        end else begin
            row_r <= row_next_s;
            col_r <= col_next_s;
        end
    end
endmodule

// File: rtl/nvcm_read_sequencer.sv
// NVCM burst read sequencer: array power-up, pump settle, per-word address/read/sample
// timing and hand-off of captured words to the bitstream consumer.
module nvcm_read_sequencer
    import nvcm_seq_pkg::*;
#(
    parameter int          ROW_W   = DEF_ROW_W,
    parameter int          COL_W   = DEF_COL_W,
    parameter int          DATA_W  = DEF_DATA_W,
    parameter int          LEN_W   = DEF_LEN_W,
    parameter int unsigned MAX_COL = DEF_MAX_COL,
    parameter int unsigned MAX_ROW = DEF_MAX_ROW,
    parameter int          T_EN    = DEF_T_EN,
    parameter int          T_PUMP  = DEF_T_PUMP,
    parameter int          T_RD    = DEF_T_RD
) (
    input  logic                  clk,
    input  logic                  rst,
    nvcm_read_sequencer_if.slave  bus,
    input  logic                  abort,
    output logic                  fsm_nvcmen,
    output logic                  fsm_pumpen,
    output logic                  fsm_rd,
    output logic                  fsm_sample,
    output logic [ROW_W-1:0]      fsm_rowadd,
    output logic [COL_W-1:0]      fsm_coladd,
    input  logic [DATA_W-1:0]     nv_dataout,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int TMR_MAX = max3(T_EN, T_PUMP, max3(T_RD, DISCH_CYCLES, 1));
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    seq_state_t        state_r, state_next_s;
    logic [TMR_W-1:0]  timer_r, timer_next_s;
    logic [LEN_W-1:0]  len_r, len_next_s;
    logic [DATA_W-1:0] dout_data_r, dout_data_next_s;
    logic              err_r, err_next_s;
    logic              done_r, done_next_s;
    logic              dout_valid_r;
    logic              req_ready_r, busy_r;
    logic              nvcmen_r, pumpen_r, rd_r, sample_r;
    logic              load_s, adv_s, at_end_s, bad_req_s;

    nvcm_addr_gen #(
        .ROW_W   (ROW_W),
        .COL_W   (COL_W),
        .MAX_ROW (MAX_ROW),
        .MAX_COL (MAX_COL)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .load_row (bus.req_row),
        .load_col (bus.req_col),
        .adv      (adv_s),
        .row      (fsm_rowadd),
        .col      (fsm_coladd),
        .at_end   (at_end_s)
    );

    assign bad_req_s = (bus.req_row > ROW_W'(MAX_ROW)) || (bus.req_col > COL_W'(MAX_COL));

    // Next-state, counters and captured data.
    always_comb begin
        state_next_s     = state_r;
        len_next_s       = len_r;
        err_next_s       = err_r;
        done_next_s      = 1'b0;
        dout_data_next_s = dout_data_r;
        load_s           = 1'b0;
        adv_s            = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req_valid && bad_req_s) begin
                    err_next_s  = 1'b1;
                    done_next_s = 1'b1;
                end else if (bus.req_valid) begin
                    load_s       = 1'b1;
                    len_next_s   = bus.req_len;
                    err_next_s   = 1'b0;
                    state_next_s = EN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            EN: begin
                if (abort)                             state_next_s = DISCH;
                else if (timer_r == TMR_W'(T_EN - 1))  state_next_s = PUMP;
                else                                   state_next_s = EN;
            end
            PUMP: begin
                if (abort)                               state_next_s = DISCH;
                else if (timer_r == TMR_W'(T_PUMP - 1))  state_next_s = ADDR;
                else                                     state_next_s = PUMP;
            end
            ADDR: begin
                state_next_s = abort ? DISCH : READ;
            end
            READ: begin
                if (abort)                             state_next_s = DISCH;
                else if (timer_r == TMR_W'(T_RD - 1))  state_next_s = SAMPLE;
                else                                   state_next_s = READ;
            end
            SAMPLE: begin
                if (abort) begin
                    state_next_s = DISCH;
                end else begin
                    dout_data_next_s = nv_dataout;
                    state_next_s     = OUT;
                end
            end
            OUT: begin
                // Abort drops the held word even if the consumer is accepting it.
                if (abort) begin
                    state_next_s = DISCH;
                end else if (bus.dout_ready && (len_r == {LEN_W{1'b0}})) begin
                    state_next_s = DISCH;
                end else if (bus.dout_ready && at_end_s) begin
                    err_next_s   = 1'b1;
                    state_next_s = DISCH;
                end else if (bus.dout_ready) begin
                    len_next_s   = len_r - LEN_W'(1);
                    adv_s        = 1'b1;
                    state_next_s = ADDR;
                end else begin
                    state_next_s = OUT;
                end
            end
            DISCH: begin
                if (timer_r == TMR_W'(DISCH_CYCLES - 1)) begin
                    state_next_s = IDLE;
                    done_next_s  = 1'b1;
                end else begin
                    state_next_s = DISCH;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Phase timer: restarts on every state change and only runs in timed states.
    always_comb begin
        timer_next_s = {TMR_W{1'b0}};
        if ((state_next_s == state_r) &&
            ((state_r == EN) || (state_r == PUMP) || (state_r == READ) || (state_r == DISCH))) begin
            timer_next_s = timer_r + TMR_W'(1);
        end else begin
            timer_next_s = {TMR_W{1'b0}};
        end
    end

    // State, counters and outputs; strobes are decoded from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            timer_r      <= {TMR_W{1'b0}};
            len_r        <= {LEN_W{1'b0}};
            dout_data_r  <= {DATA_W{1'b0}};
            dout_valid_r <= 1'b0;
            err_r        <= 1'b0;
            done_r       <= 1'b0;
            req_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            nvcmen_r     <= 1'b0;
            pumpen_r     <= 1'b0;
            rd_r         <= 1'b0;
            sample_r     <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            timer_r      <= timer_next_s;
            len_r        <= len_next_s;
            dout_data_r  <= dout_data_next_s;
            dout_valid_r <= (state_next_s == OUT);
            err_r        <= err_next_s;
            done_r       <= done_next_s;
            req_ready_r  <= (state_next_s == IDLE);
            busy_r       <= (state_next_s != IDLE);
            nvcmen_r     <= (state_next_s != IDLE);
            pumpen_r     <= (state_next_s == PUMP) || (state_next_s == ADDR) || (state_next_s == READ) ||
                            (state_next_s == SAMPLE) || (state_next_s == OUT);
            rd_r         <= (state_next_s == READ) || (state_next_s == SAMPLE);
            sample_r     <= (state_next_s == SAMPLE);
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.dout_data  = dout_data_r;
    assign bus.dout_valid = dout_valid_r & ~abort;
    assign fsm_nvcmen     = nvcmen_r;
    assign fsm_pumpen     = pumpen_r;
    assign fsm_rd         = rd_r;
    assign fsm_sample     = sample_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign err            = err_r;
endmodule

// File: tb/tb_nvcm_read_sequencer.sv
// Self-checking bench for nvcm_read_sequencer: table of burst requests plus
// hand-written back-pressure, abort and reset-in-PUMP sequences.
module tb_nvcm_read_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nvcm_read_sequencer_if #(.ROW_W(9), .COL_W(12), .DATA_W(9), .LEN_W(16)) bus ();

    logic        abort;
    logic        fsm_nvcmen, fsm_pumpen, fsm_rd, fsm_sample;
    logic [8:0]  fsm_rowadd;
    logic [11:0] fsm_coladd;
    logic [8:0]  nv_dataout;
    logic        busy, done, err;

    int n_checks = 0;
    int n_fail   = 0;

    // Array contents model: a fixed scramble of the address.
    function automatic logic [8:0] arr_word(input logic [8:0] r, input logic [11:0] c);
        return (r * 9'd37) ^ c[8:0] ^ {c[11:9], 6'h15} ^ 9'h0A5;
    endfunction

    assign nv_dataout = arr_word(fsm_rowadd, fsm_coladd);

    nvcm_read_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .abort      (abort),
        .fsm_nvcmen (fsm_nvcmen),
        .fsm_pumpen (fsm_pumpen),
        .fsm_rd     (fsm_rd),
        .fsm_sample (fsm_sample),
        .fsm_rowadd (fsm_rowadd),
        .fsm_coladd (fsm_coladd),
        .nv_dataout (nv_dataout),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [8:0]        row;
        logic [11:0]       col;
        logic [15:0]       len;
        logic              bad;
        int                words;
        logic              err;
        logic [3:0][8:0]   erow;   // element [i] is word i
        logic [3:0][11:0]  ecol;
    } vec_t;

    vec_t vecs[5];

    task automatic issue(input logic [8:0] r, input logic [11:0] c, input logic [15:0] l);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_row   = r;
        bus.req_col   = c;
        bus.req_len   = l;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int nsamp, nout, cyc, first_nvc, first_pump, first_samp, first_val;
        logic seen_done;
        logic [8:0]  srow[8];
        logic [11:0] scol[8];
        logic [8:0]  odata[8];
        nsamp = 0; nout = 0; seen_done = 1'b0;
        first_nvc = -1; first_pump = -1; first_samp = -1; first_val = -1;
        bus.dout_ready = 1'b1;
        issue(v.row, v.col, v.len);
        cyc = 1;
        check($sformatf("v%0d_err_after_accept", idx), {31'd0, err}, {31'd0, v.bad});
        while (!seen_done && cyc < 600) begin
            if (fsm_nvcmen && first_nvc < 0)     first_nvc = cyc;
            if (fsm_pumpen && first_pump < 0)    first_pump = cyc;
            if (bus.dout_valid && first_val < 0) first_val = cyc;
            if (fsm_sample) begin
                if (first_samp < 0) first_samp = cyc;
                if (nsamp < 8) begin
                    srow[nsamp] = fsm_rowadd;
                    scol[nsamp] = fsm_coladd;
                end
                nsamp++;
            end
            if (bus.dout_valid && bus.dout_ready) begin
                if (nout < 8) odata[nout] = bus.dout_data;
                nout++;
            end
            if (done) begin
                seen_done = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        check($sformatf("v%0d_done", idx), {31'd0, seen_done}, 32'd1);
        check($sformatf("v%0d_err", idx), {31'd0, err}, {31'd0, v.err});
        check($sformatf("v%0d_req_ready", idx), {31'd0, bus.req_ready}, 32'd1);
        check($sformatf("v%0d_busy", idx), {31'd0, busy}, 32'd0);
        check($sformatf("v%0d_samples", idx), nsamp, v.words);
        check($sformatf("v%0d_words", idx), nout, v.words);
        if (v.bad) begin
            check($sformatf("v%0d_no_nvcmen", idx), first_nvc, -1);
        end else begin
            check($sformatf("v%0d_nvcmen_lat", idx), first_nvc, 1);
            check($sformatf("v%0d_pumpen_lat", idx), first_pump, 9);
            check($sformatf("v%0d_first_sample", idx), first_samp, 46);
            check($sformatf("v%0d_valid_after_sample", idx), first_val - first_samp, 1);
        end
        for (int i = 0; i < v.words && i < 4; i++) begin
            if (i < nsamp) begin
                check($sformatf("v%0d_row%0d", idx, i), {23'd0, srow[i]}, {23'd0, v.erow[i]});
                check($sformatf("v%0d_col%0d", idx, i), {20'd0, scol[i]}, {20'd0, v.ecol[i]});
            end
            if (i < nout) begin
                check($sformatf("v%0d_data%0d", idx, i), {23'd0, odata[i]},
                      {23'd0, arr_word(v.erow[i], v.ecol[i])});
            end
        end
    endtask

    initial begin
        int k, bad_hold, nvalid, nsamp;
        logic [8:0] held;

        // Expected address lists are written highest word first.
        vecs[0] = '{row: 9'd0, col: 12'd0, len: 16'd0, bad: 1'b0, words: 1, err: 1'b0,
                    erow: {9'd0, 9'd0, 9'd0, 9'd0}, ecol: {12'd0, 12'd0, 12'd0, 12'd0}};
        vecs[1] = '{row: 9'd5, col: 12'd1022, len: 16'd3, bad: 1'b0, words: 4, err: 1'b0,
                    erow: {9'd6, 9'd6, 9'd5, 9'd5}, ecol: {12'd1, 12'd0, 12'd1023, 12'd1022}};
        vecs[2] = '{row: 9'd303, col: 12'd1023, len: 16'd1, bad: 1'b0, words: 1, err: 1'b1,
                    erow: {9'd0, 9'd0, 9'd0, 9'd303}, ecol: {12'd0, 12'd0, 12'd0, 12'd1023}};
        vecs[3] = '{row: 9'd0, col: 12'd1024, len: 16'd0, bad: 1'b1, words: 0, err: 1'b1,
                    erow: {9'd0, 9'd0, 9'd0, 9'd0}, ecol: {12'd0, 12'd0, 12'd0, 12'd0}};
        vecs[4] = '{row: 9'd303, col: 12'd0, len: 16'd2, bad: 1'b0, words: 3, err: 1'b0,
                    erow: {9'd0, 9'd303, 9'd303, 9'd303}, ecol: {12'd0, 12'd2, 12'd1, 12'd0}};

        rst = 1'b1; abort = 1'b0;
        bus.req_valid = 1'b0; bus.req_row = 9'd0; bus.req_col = 12'd0; bus.req_len = 16'd0;
        bus.dout_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_outputs", {24'd0, fsm_nvcmen, fsm_pumpen, fsm_rd, fsm_sample,
                              bus.dout_valid, busy, done, err}, 32'd0);
        check("rst_addr", {11'd0, fsm_rowadd, fsm_coladd}, 32'd0);
        rst = 1'b0;

        // Abort while idle has no effect.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        check("idle_abort_busy", {30'd0, busy, done}, 32'd0);

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Back-pressure: word held 20 cycles with dout_ready low.
        bus.dout_ready = 1'b0;
        issue(9'd2, 12'd3, 16'd1);
        k = 0;
        while (!bus.dout_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("bp_valid_seen", {31'd0, bus.dout_valid}, 32'd1);
        held = bus.dout_data;
        check("bp_data", {23'd0, held}, {23'd0, arr_word(9'd2, 12'd3)});
        bad_hold = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.dout_data !== held || fsm_rd !== 1'b0 || bus.dout_valid !== 1'b1 ||
                fsm_rowadd !== 9'd2 || fsm_coladd !== 12'd3) bad_hold++;
        end
        check("bp_hold_stable", bad_hold, 0);
        bus.dout_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_drop", {31'd0, bus.dout_valid}, 32'd0);
        check("bp_addr_adv", {11'd0, fsm_rowadd, fsm_coladd}, {11'd0, 9'd2, 12'd4});
        wait_done("bp_done", 100);

        // Abort during READ of word 2 of a len=5 burst.
        issue(9'd1, 12'd0, 16'd5);
        nsamp = 0; k = 0;
        while (!(fsm_rd && !fsm_sample && nsamp == 1) && k < 200) begin
            if (fsm_sample) nsamp++;
            @(negedge clk);
            k++;
        end
        check("ab_reached_read2", {31'd0, fsm_rd}, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_strobes", {28'd0, fsm_nvcmen, fsm_pumpen, fsm_rd, fsm_sample}, 32'b1000);
        nvalid = 0; k = 0;
        while (!done && k < 30) begin
            if (bus.dout_valid) nvalid++;
            if (fsm_sample) nsamp++;
            @(negedge clk);
            k++;
        end
        check("ab_no_valid", nvalid, 0);
        check("ab_samples", nsamp, 1);
        check("ab_done", {31'd0, done}, 32'd1);

        // Reset asserted during PUMP.
        issue(9'd0, 12'd0, 16'd0);
        k = 0;
        while (!fsm_pumpen && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("rp_in_pump", {31'd0, fsm_pumpen}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rp_strobes", {28'd0, fsm_nvcmen, fsm_pumpen, fsm_rd, fsm_sample}, 32'd0);
        check("rp_ready_busy", {30'd0, bus.req_ready, busy}, 32'b10);
        rst = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nvcm_read_sequencer.md
Name: nvcm_read_sequencer

Overview:
- Sequences burst reads of the NVCM array for the configuration-load path: power-up, charge-pump settle, per-word address/read/sample timing, and streaming of captured words to the downstream bitstream consumer.
- Sits between the bitstream-load control and the NVCM macro strobes (fsm_nvcmen, fsm_pumpen, fsm_rd, fsm_sample, fsm_rowadd, fsm_coladd, nv_dataout).
- Owns all read timing.
- The program/verify path is outside this block's scope.

Parameters:
ROW_W, 9, row address width (fsm_rowadd)
COL_W, 12, column address width (fsm_coladd)
DATA_W, 9, array data width (nv_dataout)
LEN_W, 16, burst length counter width
MAX_COL, 12'd1023, last valid column; the column wraps to 0 after it and the row increments
MAX_ROW, 9'd303, last valid row
T_EN, 8, cycles from fsm_nvcmen rise to pump enable
T_PUMP, 32, pump settle cycles
T_RD, 4, cycles fsm_rd is high before sample

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  burst request
req_ready  out  1  high only in IDLE
req_row  in  ROW_W  start row
req_col  in  COL_W  start column
req_len  in  LEN_W  word count minus one
abort  in  1  terminate burst
fsm_nvcmen  out  1  array enable
fsm_pumpen  out  1  read pump enable
fsm_rd  out  1  read strobe
fsm_sample  out  1  one-cycle sense-amp capture
fsm_rowadd  out  ROW_W  row address
fsm_coladd  out  COL_W  column address
nv_dataout  in  DATA_W  array read data
dout_data  out  DATA_W  captured word
dout_valid  out  1  word available
dout_ready  in  1  consumer accepts
busy  out  1  not IDLE
done  out  1  one-cycle pulse at end of burst
err  out  1  sticky address overflow; cleared by next accepted request

Behaviour:
- Reset: state IDLE. All outputs 0, except req_ready = 1. Counters are cleared.
- Reset mid-burst forces IDLE on the next edge. All strobes drop in that same cycle.
- IDLE:
  - When req_valid && req_ready, latch row, col and len; clear err; go to EN.
  - If req_row > MAX_ROW or req_col > MAX_COL, set err, pulse done, and stay in IDLE.
- EN: fsm_nvcmen = 1. After T_EN cycles, go to PUMP.
- PUMP: fsm_nvcmen = fsm_pumpen = 1. After T_PUMP cycles, go to ADDR.
- ADDR: one cycle. Address outputs are registered and stable from this cycle through SAMPLE.
- READ: fsm_rd = 1 for T_RD cycles, then go to SAMPLE.
- SAMPLE:
  - fsm_rd = fsm_sample = 1 for one cycle.
  - dout_data <= nv_dataout at the end of this cycle.
  - dout_valid is set on the next cycle; go to OUT.
- OUT:
  - Hold dout_data/dout_valid until dout_ready.
  - nvcmen/pumpen stay high; rd = 0.
  - On handshake, if the length counter is 0, go to DISCH.
  - Otherwise, decrement the counter and advance the address, then go to ADDR.
- Address advance:
  - col == MAX_COL → col = 0, row + 1.
  - If row == MAX_ROW also wraps, set err and go to DISCH. The overflowing word is not read.
- Steady-state per-word latency from ADDR to dout_valid: T_RD + 2 cycles.
- DISCH:
  - fsm_nvcmen = 1, pumpen = 0, for 2 cycles.
  - Then go to IDLE and pulse done.
- abort:
  - Sampled in every non-IDLE state. Takes priority over handshake and advance.
  - Next state is DISCH; dout_valid drops immediately; no further words are produced.
  - abort in IDLE is ignored.
- Simultaneous dout_ready and abort: abort wins and the word is dropped.
- All state and timer counters are width-sized to their max parameter; no counter wraps inside a state.

Decomposition:
- Package nvcm_seq_pkg holds:
  - the state enum (IDLE, EN, PUMP, ADDR, READ, SAMPLE, OUT, DISCH);
  - default timing constants;
  - MAX_ROW/MAX_COL defaults for the 1F array geometry.
- One sub-module, nvcm_addr_gen: loadable row/col counter with wrap and overflow flag, used by the sequencer's advance step.

Test Plan:
- Reset, then a request with row=0, col=0, len=0 and dout_ready tied 1:
  - nvcmen rises 1 cycle after accept;
  - pumpen rises 8 cycles later;
  - fsm_sample pulses once with addr 0/0;
  - dout_data equals the modelled array word;
  - done pulses after DISCH; req_ready returns to 1.
- Request with col=1022, len=3: addresses (r,1022), (r,1023), (r+1,0), (r+1,1) in order, each with exactly one sample pulse.
- Request with row=303, col=1023, len=1: one word is delivered, then err=1; no second sample pulse; done pulses.
- Hold dout_ready=0 for 20 cycles in OUT: dout_data is stable, fsm_rd stays 0, and there is no address change until the handshake.
- Assert abort during the READ of word 2 of a len=5 burst: dout_valid never rises for word 2; pumpen drops the next cycle; done pulses.
- Assert rst during PUMP: the next cycle has all strobes 0, req_ready=1, busy=0.
- Request with req_col=1024: no strobes toggle, err=1, done pulses; the next valid request clears err.
